// File: rtl/uart_rx_fifo.sv
// Receive buffer between the UART receiver and the CPU IO page.
// A capture FSM takes each byte offered by the UART, stores it in a FIFO, and
// acknowledges the UART with a one-cycle uart_rd pulse. The CPU drains the FIFO
// through the data register read strobe.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetq,
  input  logic                  uart_valid,
  input  logic [7:0]            uart_data,
  output logic                  uart_rd,
  input  logic                  pop,
  output logic [7:0]            rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CountFull = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StAck,
    StWait
  } state_e;

  state_e                  r_state;
  logic                    r_uart_rd;
  logic [7:0]              r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]     r_count;
  logic                    r_overflow;

  logic                    w_empty;
  logic                    w_full;
  logic                    w_push;
  logic                    w_pop_ok;
  logic                    w_push_ok;

  // Capture happens only on the IDLE edge; a pop at full frees the slot for it.
  always_comb begin
    w_empty   = (r_count == '0);
    w_full    = (r_count == CountFull);
    w_push    = (r_state == StIdle) && uart_valid;
    w_pop_ok  = pop && !w_empty;
    w_push_ok = w_push && (!w_full || w_pop_ok);
  end

  // Capture FSM: IDLE captures, ACK pulses uart_rd, WAIT holds until the UART drops valid.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_state   <= StIdle;
      r_uart_rd <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (uart_valid) begin
            r_state   <= StAck;
            r_uart_rd <= 1'b1;
          end
        end
        StAck: begin
          r_state   <= StWait;
          r_uart_rd <= 1'b0;
        end
        StWait: begin
          if (!uart_valid) r_state <= StIdle;
        end
        default: begin
          r_state   <= StIdle;
          r_uart_rd <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately not reset so it maps onto a plain register file.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= uart_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: a dropped byte wins over a same-cycle clear.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_overflow <= 1'b0;
    end else if (w_push && !w_push_ok) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  // Head byte is combinational so the byte shown in the pop cycle is the one consumed.
  assign rdata    = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign uart_rd  = r_uart_rd;
  assign count    = r_count;
  assign empty    = w_empty;
  assign full     = w_full;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: stimulus pushes expected bytes into a queue, a monitor
// compares every consumed head byte against it; status flags are checked inline.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       resetq;
  logic       uart_valid;
  logic [7:0] uart_data;
  logic       uart_rd;
  logic       pop;
  logic [7:0] rdata;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       clr_overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int rd_pulses = 0;
  logic [7:0] exp_q [$];

  uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk          (clk),
    .resetq       (resetq),
    .uart_valid   (uart_valid),
    .uart_data    (uart_data),
    .uart_rd      (uart_rd),
    .pop          (pop),
    .rdata        (rdata),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: every effective pop must present the oldest expected byte.
  always @(negedge clk) begin
    if (resetq && pop) begin
      if (empty) begin
        check("rdata_when_empty", {24'h0, rdata}, 32'h0);
      end else if (exp_q.size() == 0) begin
        check("pop_unexpected", 32'h1, 32'h0);
      end else begin
        check("pop_data", {24'h0, rdata}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) if (uart_rd) rd_pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte, hold valid for 'hold' cycles, and verify a single ack pulse.
  task automatic send_byte(input logic [7:0] d, input int hold, input bit accept);
    int base;
    uart_data  = d;
    uart_valid = 1'b1;
    base = rd_pulses;
    check("rd_before_capture", {31'h0, uart_rd}, 32'h0);
    if (accept) exp_q.push_back(d);
    cycle();
    check("rd_after_capture", {31'h0, uart_rd}, 32'h1);
    repeat (hold - 1) cycle();
    uart_valid = 1'b0;
    cycle();
    cycle();
    check("rd_pulse_count", rd_pulses - base, 32'd1);
  endtask

  task automatic pop_n(input int n);
    pop = 1'b1;
    repeat (n) cycle();
    pop = 1'b0;
  endtask

  initial begin
    resetq = 1'b0;
    uart_valid = 1'b0;
    uart_data = 8'h00;
    pop = 1'b0;
    clr_overflow = 1'b0;
    #3;
    check("init_count", {27'h0, count}, 32'd0);
    check("init_empty", {31'h0, empty}, 32'd1);
    check("init_rd", {31'h0, uart_rd}, 32'd0);
    @(negedge clk);
    resetq = 1'b1;
    cycle();

    // Mid-clock asynchronous reset with data buffered.
    send_byte(8'h12, 2, 1'b1);
    send_byte(8'h34, 2, 1'b1);
    check("pre_reset_count", {27'h0, count}, 32'd2);
    #3;
    resetq = 1'b0;
    #1;
    exp_q.delete();
    check("rst_count", {27'h0, count}, 32'd0);
    check("rst_empty", {31'h0, empty}, 32'd1);
    check("rst_full", {31'h0, full}, 32'd0);
    check("rst_overflow", {31'h0, overflow}, 32'd0);
    check("rst_rd", {31'h0, uart_rd}, 32'd0);
    check("rst_rdata", {24'h0, rdata}, 32'h0);
    @(negedge clk);
    resetq = 1'b1;
    cycle();

    // Single byte held 5 cycles.
    send_byte(8'h41, 5, 1'b1);
    check("single_count", {27'h0, count}, 32'd1);
    check("single_rdata", {24'h0, rdata}, 32'h41);
    pop_n(1);
    check("single_empty", {31'h0, empty}, 32'd1);
    check("single_rdata_empty", {24'h0, rdata}, 32'h0);

    // Fill, then overflow with 0xAA.
    for (int i = 0; i < 16; i++) send_byte(8'(i), 2, 1'b1);
    check("fill_full", {31'h0, full}, 32'd1);
    check("fill_count", {27'h0, count}, 32'd16);
    check("fill_ovf", {31'h0, overflow}, 32'd0);
    send_byte(8'hAA, 2, 1'b0);
    check("ovf_set", {31'h0, overflow}, 32'd1);
    check("ovf_count", {27'h0, count}, 32'd16);
    pop_n(16);
    check("drain_empty", {31'h0, empty}, 32'd1);
    check("ovf_sticky", {31'h0, overflow}, 32'd1);
    clr_overflow = 1'b1;
    cycle();
    clr_overflow = 1'b0;
    check("ovf_clear", {31'h0, overflow}, 32'd0);

    // Wrap-around.
    for (int i = 0; i < 10; i++) send_byte(8'h10 + 8'(i), 2, 1'b1);
    pop_n(10);
    for (int i = 0; i < 10; i++) send_byte(8'h50 + 8'(i), 2, 1'b1);
    check("wrap_count", {27'h0, count}, 32'd10);
    pop_n(10);
    check("wrap_end_count", {27'h0, count}, 32'd0);

    // Simultaneous push and pop at full.
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 2, 1'b1);
    uart_data = 8'h77;
    uart_valid = 1'b1;
    pop = 1'b1;
    exp_q.push_back(8'h77);
    cycle();
    pop = 1'b0;
    check("simfull_count", {27'h0, count}, 32'd16);
    check("simfull_ovf", {31'h0, overflow}, 32'd0);
    check("simfull_rd", {31'h0, uart_rd}, 32'd1);
    uart_valid = 1'b0;
    cycle();
    cycle();
    pop_n(15);
    check("simfull_last", {24'h0, rdata}, 32'h77);
    pop_n(1);
    check("simfull_empty", {31'h0, empty}, 32'd1);

    // Simultaneous push and pop at empty: pop ignored.
    uart_data = 8'h77;
    uart_valid = 1'b1;
    pop = 1'b1;
    exp_q.push_back(8'h77);
    cycle();
    pop = 1'b0;
    check("simempty_count", {27'h0, count}, 32'd1);
    check("simempty_rdata", {24'h0, rdata}, 32'h77);
    uart_valid = 1'b0;
    cycle();
    cycle();
    pop_n(1);

    // Reset while in WAIT with valid held and 5 bytes buffered.
    for (int i = 0; i < 4; i++) send_byte(8'h60 + 8'(i), 2, 1'b1);
    uart_data = 8'h64;
    uart_valid = 1'b1;
    cycle();
    cycle();
    check("midop_count", {27'h0, count}, 32'd5);
    #2;
    resetq = 1'b0;
    #1;
    exp_q.delete();
    check("midop_rst_count", {27'h0, count}, 32'd0);
    check("midop_rst_rd", {31'h0, uart_rd}, 32'd0);
    check("midop_rst_rdata", {24'h0, rdata}, 32'h0);
    @(negedge clk);
    resetq = 1'b1;
    send_byte(8'h64, 3, 1'b1);
    check("midop_recapture_count", {27'h0, count}, 32'd1);
    check("midop_recapture_rdata", {24'h0, rdata}, 32'h64);
    pop_n(1);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer between the buart receiver and the CPU IO page.
- A capture FSM accepts each byte flagged by the UART `valid`, stores it in a FIFO, and acknowledges the UART with a one-cycle `rd` pulse.
- The CPU drains the FIFO through the UART data register read strobe, so bytes are not lost while the CPU is busy (e.g. scrolling the character RAM).
- Status (count, empty, full, sticky overflow) is exported for the UART control register.

Parameters:
- DEPTH_LOG2, 4: log2 of FIFO depth. DEPTH = 2**DEPTH_LOG2 = 16 entries of 8 bits.

Ports:
- clk  in  1  system clock (50 MHz pixel/CPU clock).
- resetq  in  1  asynchronous, active-low reset.
- uart_valid  in  1  buart has a received byte pending.
- uart_data  in  8  buart received byte, stable while uart_valid=1.
- uart_rd  out  1  one-cycle acknowledge to buart; clears its valid.
- pop  in  1  CPU read strobe on the UART data register (io_rstrb & data bit).
- rdata  out  8  FIFO head byte; 0x00 when empty.
- count  out  DEPTH_LOG2+1  number of stored bytes, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- clr_overflow  in  1  clears overflow (CPU write to the UART control register).

Behaviour:
- Reset (resetq=0, async): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, overflow=0, uart_rd=0, FSM=IDLE, rdata=0x00. Storage contents are not reset.
- FSM states and transitions:
  - IDLE: when uart_valid=1, push uart_data at this edge, then go to ACK.
  - ACK: uart_rd=1 for exactly this one cycle, then go to WAIT.
  - WAIT: stay until uart_valid=0, then go to IDLE. This prevents double capture while buart deasserts valid.
- uart_rd is a registered output, high only in ACK.
- Push-to-ack latency: uart_rd rises 1 cycle after the capture edge. Minimum byte-to-byte spacing is 3 cycles, far below the UART character time.
- The UART is always acknowledged, even when the byte is dropped, so the receiver never stalls.
- Push when not full: mem[wr_ptr] <= uart_data; wr_ptr increments modulo DEPTH; count increments.
- Push when full without a simultaneous pop: byte discarded, overflow <= 1, pointers and count unchanged.
- Pop when not empty: rd_ptr increments modulo DEPTH; count decrements.
- rdata is combinational from mem[rd_ptr], so the byte presented during the pop cycle is the byte consumed. This matches the IO read buffering in the same cycle as the read strobe.
- Pop when empty: no effect; rdata=0x00.
- Simultaneous push and pop:
  - Not empty and not full: both execute; count unchanged.
  - Full: the pop frees a slot and the push is accepted. count stays DEPTH, overflow is not set.
  - Empty: the pop is ignored and the push is accepted; count=1. The new byte is visible on rdata the next cycle.
- empty and full are derived from the registered count.
- Pointers are DEPTH_LOG2 bits and wrap naturally.
- overflow: set has priority over clr_overflow in the same cycle. Otherwise clr_overflow=1 clears it.
- Reset mid-operation (any FSM state, any count): all state returns to reset values immediately and buffered bytes are discarded. If uart_valid=1 after reset release, IDLE captures it normally.
- Implementation: storage is an inferred register file (or RAM with a read-before-write bypass). No combinational path from uart_valid to uart_rd.

Test Plan:
- Reset: assert resetq=0 mid-clock -> immediately count=0, empty=1, full=0, overflow=0, uart_rd=0, rdata=0x00.
- Single byte: uart_valid=1 with data 0x41 held 5 cycles -> exactly one uart_rd pulse, 1 cycle after capture; count=1, rdata=0x41. One pop -> empty=1, rdata=0x00.
- Overflow: push 0x00..0x0F, then 0xAA:
  - full=1 and count=16; 0xAA still gets its uart_rd pulse; overflow=1.
  - 16 pops return 0x00..0x0F in order; clr_overflow -> overflow=0.
- Wrap-around: push 10 bytes, pop 10, push 10 (0x50..0x59) -> pointers wrap past 15, pops return 0x50..0x59, count ends at 0.
- Simultaneous at full: FIFO full, pop and capture of 0x77 in the same cycle -> count stays 16, overflow stays 0, 0x77 is the last byte drained. The same test at empty -> count=1, rdata=0x77.
- Reset mid-operation: count=5, FSM in WAIT with uart_valid=1, pulse resetq low -> all cleared. After release, the held byte is captured once, with a single uart_rd pulse.
